// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store control unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane formatting: store mask/data, load extension and fault decode.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_store_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      wmask_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_ext_o,
    output logic            misalign_o,
    output logic            badop_o
);

    logic [XLEN-1:0] shifted;

    // Store formatting and fault decode; misalign is only raised for legal funct3,
    // so badop naturally wins.
    always_comb begin
        wmask_o    = 4'b0000;
        wdata_o    = '0;
        misalign_o = 1'b0;
        badop_o    = 1'b0;
        if (is_store_i) begin
            case (funct3_i)
                F3_B: begin
                    wmask_o = 4'b0001 << addr_lo_i;
                    wdata_o = {(XLEN/8){wdata_i[7:0]}};
                end
                F3_H: begin
                    misalign_o = addr_lo_i[0];
                    wmask_o    = 4'b0011 << addr_lo_i;
                    wdata_o    = {(XLEN/16){wdata_i[15:0]}};
                end
                F3_W: begin
                    misalign_o = |addr_lo_i;
                    wmask_o    = 4'b1111;
                    wdata_o    = wdata_i;
                end
                default: badop_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                F3_B, F3_BU: ;
                F3_H, F3_HU: misalign_o = addr_lo_i[0];
                F3_W:        misalign_o = |addr_lo_i;
                default:     badop_o = 1'b1;
            endcase
        end
    end

    // Load alignment: shift the addressed lane down, then extend per funct3.
    always_comb begin
        shifted     = rdata_i >> {addr_lo_i, 3'b000};
        rdata_ext_o = '0;
        case (funct3_i)
            F3_B:    rdata_ext_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata_ext_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_H:    rdata_ext_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata_ext_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
            F3_W:    rdata_ext_o = shifted;
            default: rdata_ext_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: EXU handshake in, one memory transaction, result out to WBU.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_store,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata,
    output logic            out_misalign,
    output logic            out_badop
);

    lsu_state_e      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      wmask_q, wmask_d;
    logic            wen_q, wen_d;
    logic            is_store_q, is_store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            misalign_q, misalign_d;
    logic            badop_q, badop_d;

    // One align instance: fed by the incoming op in IDLE, by the latched op otherwise.
    logic            sel_in;
    logic            al_is_store;
    logic [2:0]      al_funct3;
    logic [1:0]      al_addr_lo;
    logic [3:0]      al_wmask;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata_ext;
    logic            al_misalign;
    logic            al_badop;
    logic            al_fault;

    assign sel_in      = (state_q == StIdle);
    assign al_is_store = sel_in ? in_is_store  : is_store_q;
    assign al_funct3   = sel_in ? in_funct3    : funct3_q;
    assign al_addr_lo  = sel_in ? in_addr[1:0] : addr_lo_q;
    assign al_fault    = al_misalign | al_badop;

    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .is_store_i (al_is_store),
        .funct3_i   (al_funct3),
        .addr_lo_i  (al_addr_lo),
        .wdata_i    (in_wdata),
        .rdata_i    (mem_rdata),
        .wmask_o    (al_wmask),
        .wdata_o    (al_wdata),
        .rdata_ext_o(al_rdata_ext),
        .misalign_o (al_misalign),
        .badop_o    (al_badop)
    );

    // Next-state and handshake outputs; latched fields hold unless explicitly updated.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        wen_d         = wen_q;
        is_store_d    = is_store_q;
        funct3_d      = funct3_q;
        addr_lo_d     = addr_lo_q;
        rdata_d       = rdata_q;
        misalign_d    = misalign_q;
        badop_d       = badop_q;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    addr_d     = {in_addr[XLEN-1:2], 2'b00};
                    is_store_d = in_is_store;
                    funct3_d   = in_funct3;
                    addr_lo_d  = in_addr[1:0];
                    misalign_d = al_misalign;
                    badop_d    = al_badop;
                    rdata_d    = '0;
                    // Loads and faulted ops never drive write lanes.
                    wen_d      = in_is_store & ~al_fault;
                    wmask_d    = wen_d ? al_wmask : 4'b0000;
                    wdata_d    = wen_d ? al_wdata : '0;
                    state_d    = al_fault ? StDone : StReq;
                end
            end
            StReq: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = StWait;
            end
            StWait: begin
                if (mem_resp_valid) begin
                    rdata_d = is_store_q ? '0 : al_rdata_ext;
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and latched-field registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= 4'b0000;
            wen_q      <= 1'b0;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_lo_q  <= 2'b00;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            badop_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            wen_q      <= wen_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_lo_q  <= addr_lo_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            badop_q    <= badop_d;
        end
    end

    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wmask    = wmask_q;
    assign mem_wen      = wen_q;
    assign out_rdata    = rdata_q;
    assign out_misalign = misalign_q;
    assign out_badop    = badop_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: aligned loads/stores, faults, backpressure, reset abort.
module tb_lsu_ctrl;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_misalign;
    logic        out_badop;

    int checks = 0;
    int errors = 0;

    lsu_ctrl #(
        .XLEN(32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_is_store   (in_is_store),
        .in_funct3     (in_funct3),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rdata     (out_rdata),
        .out_misalign  (out_misalign),
        .out_badop     (out_badop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full zero-wait transaction: accept, REQ, WAIT, DONE, back to IDLE.
    task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input logic [31:0] e_addr,
                          input logic e_wen, input logic [3:0] e_mask,
                          input logic [31:0] e_wdata, input logic [31:0] e_rdata);
        in_valid       = 1'b1;
        in_is_store    = st;
        in_funct3      = f3;
        in_addr        = addr;
        in_wdata       = wd;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        out_ready      = 1'b0;
        chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk({tag, ".req_valid"}, 32'(mem_req_valid), 32'd1);
        chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        chk({tag, ".mem_addr"}, mem_addr, e_addr);
        chk({tag, ".mem_wen"}, 32'(mem_wen), 32'(e_wen));
        chk({tag, ".mem_wmask"}, 32'(mem_wmask), 32'(e_mask));
        chk({tag, ".mem_wdata"}, mem_wdata, e_wdata);
        mem_resp_valid = 1'b1;
        mem_rdata      = rd;
        step();
        chk({tag, ".wait_no_req"}, 32'(mem_req_valid), 32'd0);
        chk({tag, ".wait_no_out"}, 32'(out_valid), 32'd0);
        step();
        mem_resp_valid = 1'b0;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".out_rdata"}, out_rdata, e_rdata);
        chk({tag, ".misalign"}, 32'(out_misalign), 32'd0);
        chk({tag, ".badop"}, 32'(out_badop), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".done_exit"}, 32'(out_valid), 32'd0);
        chk({tag, ".ready_again"}, 32'(in_ready), 32'd1);
    endtask

    // Faulting op: result one cycle after accept, no memory request at all.
    task automatic run_fault(input string tag, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic e_mis, input logic e_bad);
        in_valid      = 1'b1;
        in_is_store   = st;
        in_funct3     = f3;
        in_addr       = addr;
        in_wdata      = 32'hFFFF_FFFF;
        mem_req_ready = 1'b1;
        out_ready     = 1'b0;
        step();
        in_valid = 1'b0;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".no_req"}, 32'(mem_req_valid), 32'd0);
        chk({tag, ".misalign"}, 32'(out_misalign), 32'(e_mis));
        chk({tag, ".badop"}, 32'(out_badop), 32'(e_bad));
        chk({tag, ".rdata"}, out_rdata, 32'h0);
        chk({tag, ".wen"}, 32'(mem_wen), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".idle"}, 32'(in_ready), 32'd1);
        chk({tag, ".idle_no_req"}, 32'(mem_req_valid), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_is_store    = 1'b0;
        in_funct3      = 3'b000;
        in_addr        = 32'h0;
        in_wdata       = 32'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
        out_ready      = 1'b0;
        step();
        step();
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.mem_wmask", 32'(mem_wmask), 32'h0);
        chk("rst.out_rdata", out_rdata, 32'h0);
        reset = 1'b0;
        step();

        run_op("lb", 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234,
               32'h8000_0000, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80);
        run_op("lhu", 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'hBEEF_0000,
               32'h8000_0000, 1'b0, 4'b0000, 32'h0, 32'h0000_BEEF);
        run_op("lh", 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'hBEEF_0000,
               32'h8000_0000, 1'b0, 4'b0000, 32'h0, 32'hFFFF_BEEF);
        run_op("lbu", 1'b0, 3'b100, 32'h0000_0101, 32'h0, 32'h1122_9A44,
               32'h0000_0100, 1'b0, 4'b0000, 32'h0, 32'h0000_009A);
        run_op("sh", 1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h5555_5555,
               32'h8000_0000, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0);
        run_op("sb", 1'b1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'h0,
               32'h8000_0000, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0);

        run_fault("lw_mis", 1'b0, 3'b010, 32'h8000_0001, 1'b1, 1'b0);
        run_fault("lh_mis", 1'b0, 3'b001, 32'h8000_0003, 1'b1, 1'b0);
        run_fault("ld_bad", 1'b0, 3'b011, 32'h8000_0000, 1'b0, 1'b1);
        // Reserved store funct3 at an odd address: badop wins over misalign.
        run_fault("st_bad", 1'b1, 3'b101, 32'h8000_0001, 1'b0, 1'b1);

        // Backpressure on every handshake; a response during REQ must be ignored.
        in_valid       = 1'b1;
        in_is_store    = 1'b1;
        in_funct3      = 3'b010;
        in_addr        = 32'h0000_0020;
        in_wdata       = 32'hCAFE_F00D;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        out_ready      = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp.req_valid", 32'(mem_req_valid), 32'd1);
            chk("bp.req_addr", mem_addr, 32'h0000_0020);
            chk("bp.req_wdata", mem_wdata, 32'hCAFE_F00D);
            chk("bp.req_wmask", 32'(mem_wmask), 32'hF);
            chk("bp.req_wen", 32'(mem_wen), 32'd1);
            chk("bp.req_in_ready", 32'(in_ready), 32'd0);
            if (i == 2) begin
                mem_req_ready  = 1'b1;
                mem_resp_valid = 1'b0;
            end
            step();
        end
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("bp.wait_no_req", 32'(mem_req_valid), 32'd0);
            chk("bp.wait_no_out", 32'(out_valid), 32'd0);
            chk("bp.wait_addr", mem_addr, 32'h0000_0020);
            chk("bp.wait_in_ready", 32'(in_ready), 32'd0);
            if (i == 1) mem_resp_valid = 1'b1;
            step();
        end
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp.out_valid", 32'(out_valid), 32'd1);
            chk("bp.out_rdata", out_rdata, 32'h0);
            chk("bp.done_in_ready", 32'(in_ready), 32'd0);
            if (i == 2) out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        chk("bp.single_result", 32'(out_valid), 32'd0);
        chk("bp.in_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp.still_idle", 32'(out_valid), 32'd0);

        // Reset while waiting for the response, then a stale response arrives.
        in_valid      = 1'b1;
        in_is_store   = 1'b0;
        in_funct3     = 3'b010;
        in_addr       = 32'h0000_0040;
        mem_req_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("rw.in_wait", 32'(mem_req_valid), 32'd0);
        reset = 1'b1;
        step();
        reset          = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hDEAD_BEEF;
        chk("rw.aborted", 32'(in_ready), 32'd1);
        step();
        mem_resp_valid = 1'b0;
        chk("rw.stale_out", 32'(out_valid), 32'd0);
        chk("rw.stale_rdata", out_rdata, 32'h0);
        chk("rw.idle", 32'(in_ready), 32'd1);
        chk("rw.no_req", 32'(mem_req_valid), 32'd0);
        run_op("sw", 1'b1, 3'b010, 32'h0000_0044, 32'h1122_3344, 32'h0,
               32'h0000_0044, 1'b1, 4'b1111, 32'h1122_3344, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Multi-cycle load/store control unit between the execute stage and the DPI memory port. It accepts one load or store per transaction from EXU over a valid/ready handshake. It formats byte, half and word stores into a word-aligned address, write data and byte mask, and issues them on a request/response memory handshake. It aligns and sign- or zero-extends load data before handing the result to writeback. Misaligned addresses and reserved funct3 values are trapped locally and never reach memory.

## Interface
Parameters:
- `XLEN`, 32: address and data width.

Ports:
- `clock`  in  1  Sole clock; all state updates on its rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `in_valid`  in  1  EXU presents an operation.
- `in_ready`  out  1  LSU can accept an operation.
- `in_is_store`  in  1  1 = store, 0 = load.
- `in_funct3`  in  3  RV32I funct3 (size and signedness).
- `in_addr`  in  XLEN  Effective byte address.
- `in_wdata`  in  XLEN  Store source register value.
- `mem_req_valid`  out  1  Memory request pending.
- `mem_req_ready`  in  1  Memory accepts the request.
- `mem_wen`  out  1  Request is a write.
- `mem_addr`  out  XLEN  Word-aligned address (`in_addr & ~3`).
- `mem_wdata`  out  XLEN  Lane-replicated store data.
- `mem_wmask`  out  4  Byte write mask.
- `mem_resp_valid`  in  1  Read data, or write acknowledge, is available.
- `mem_rdata`  in  XLEN  Raw word read from memory.
- `out_valid`  out  1  Result is available to WBU.
- `out_ready`  in  1  WBU consumes the result.
- `out_rdata`  out  XLEN  Extended load result; 0 for stores and faults.
- `out_misalign`  out  1  Address misaligned for the access size.
- `out_badop`  out  1  Reserved funct3.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On handshake, latch the operation. A fault goes to DONE; otherwise go to REQ.
  - REQ: `mem_req_valid`=1 with the latched fields held stable. On `mem_req_ready`, go to WAIT.
  - WAIT: on `mem_resp_valid`, latch the extended data (loads only) and go to DONE.
  - DONE: `out_valid`=1 with outputs held. On `out_ready`, go to IDLE.
- Supported loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- Supported stores: SB=000, SH=001, SW=010.
- Every other funct3 (per direction) sets `out_badop` and issues no memory request.
- Misalignment (`out_misalign`):
  - Half access with `addr[0]`=1.
  - Word access with `addr[1:0]`≠0.
  - No memory request is issued.
- Store write mask:
  - SB: `4'b0001 << addr[1:0]`.
  - SH: `4'b0011 << addr[1:0]`.
  - SW: `4'b1111`.
- Store write data:
  - SB: byte replicated four times.
  - SH: half replicated twice.
  - SW: unchanged.
- Loads drive `mem_wmask`=0 and `mem_wen`=0.
- Load result:
  - `shifted = mem_rdata >> (8*addr[1:0])`.
  - Sign- or zero-extend bit 7 or bit 15 of `shifted` per funct3.
  - LW passes `shifted` unchanged.
- Stores complete on `mem_resp_valid` (write acknowledge) with `out_rdata`=0.
- Fault flags are mutually exclusive; `out_badop` takes priority.

## Timing
- Reset values: state=IDLE, `in_ready`=1, every other output 0, all latched fields 0.
- Reset mid-transaction aborts to IDLE. A `mem_resp_valid` arriving in IDLE or REQ is ignored.
- Minimum latency: accept at cycle t, `mem_req_valid` at t+1 (`mem_req_ready`=1), response at t+2, `out_valid` at t+3.
- Fault latency: accept at t, `out_valid` at t+1.
- Backpressure:
  - `mem_req_valid` stays high until `mem_req_ready`.
  - `out_valid` stays high until `out_ready`.
  - No combinational path from `out_ready` to `in_ready`. The next operation is accepted the cycle after DONE exits.
- One outstanding memory transaction at most; `mem_resp_valid` is honoured only in WAIT.

## Structure
- `lsu_pkg` holds the state enum (IDLE/REQ/WAIT/DONE) and the funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
- One combinational sub-module, `lsu_align`. It maps funct3, `addr[1:0]` and the raw data to `wmask`, lane-replicated `wdata`, the extended load data and the fault flags. It is reused for both directions.

## Test plan
- LB at 0x8000_0003, `mem_rdata`=0x80FF_1234 -> `mem_addr`=0x8000_0000, `mem_wmask`=0, `out_rdata`=0xFFFF_FF80, no fault.
- LHU at 0x8000_0002, `mem_rdata`=0xBEEF_0000 -> `out_rdata`=0x0000_BEEF. LH at the same address -> `out_rdata`=0xFFFF_BEEF.
- SH at 0x8000_0002, `in_wdata`=0x1234_ABCD -> `mem_wen`=1, `mem_wmask`=4'b1100, `mem_wdata`=0xABCD_ABCD, `out_rdata`=0.
- LW at 0x8000_0001 -> `out_misalign`=1 at t+1, `mem_req_valid` never asserted. Load funct3=011 -> `out_badop`=1.
- Backpressure: `mem_req_ready` low 3 cycles then high, response delayed 2 cycles, `out_ready` low 2 cycles -> all mem-side fields stable throughout, exactly one result delivered, `in_ready` low until DONE exits.
- `reset` asserted in WAIT, then a stale `mem_resp_valid` next cycle -> FSM in IDLE, `out_valid`=0, response ignored; the following SW completes normally.
